qbus_slave_seq: RTL
===================

// Module: qbus_slave_seq
// PURPOSE
//  Clocked Qbus slave cycle sequencer between the Qbus pin drivers and the MSCP
//  register file. Decodes programmed-I/O DATI/DATO(B)/DATIO cycles at QADDR and
//  turns them into single-cycle reg_rd/reg_wr strobes on the 'clock' domain.
//  It generates BRPLYg, BDAL drive and Outbound with correct Qbus setup and hold.
//  It also aborts hung cycles and BINIT.
// PARAMETERS
//  QADDR          22'o17772150  base of 4-word window; match = BBS7 && addr[12:3]==QADDR[12:3]
//  SYNC_STAGES    2             flops per strobe synchronizer (>=2)
//  REPLY_SETUP    2             clocks BDAL data is driven before BRPLYg asserts (>=1)
//  TIMEOUT_CYCLES 1023          clocks in any active state before abort (10-bit counter)
// PORTS
//  clock      in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  BDALf_IN   in   22  Qbus BDAL, inverted (low = asserted)
//  BSYNCf     in   1   BSYNC, inverted, async
//  BDINf      in   1   BDIN, inverted, async
//  BDOUTf     in   1   BDOUT, inverted, async
//  BWTBTf     in   1   BWTBT, inverted, async
//  BBS7f      in   1   BBS7, inverted, async
//  BINITf     in   1   BINIT, inverted, async
//  BDALf_OUT  out  22  inverted data to BDAL pins
//  BDALf_OE   out  22  FPGA pin output enables
//  Outbound   out  1   BDAL gate-driver enable
//  BRPLYg     out  1   BRPLY MOSFET gate (1 = assert RPLY)
//  reg_addr   out  2   register word index = Qaddress[2:1]
//  reg_rd     out  1   1-cycle read strobe; reg_rdata valid the following cycle
//  reg_rdata  in   16  read data from register file
//  reg_wr     out  1   1-cycle write strobe
//  reg_be     out  2   byte enables [1]=high byte [0]=low byte, valid with reg_wr
//  reg_wdata  out  16  write data (true polarity) = ~BDALf_IN[15:0]
//  busy       out  1   state != IDLE
//  timeout_err out 1   sticky: set on timeout abort, cleared only by reset
// BEHAVIOUR
//  - Address/BBS7/BWTBT latched on negedge BSYNCf (true polarity). Held until next BSYNC.
//    The state machine reads them only after the synchronized BSYNC assertion.
//  - BSYNCf/BDINf/BDOUTf/BWTBTf/BINITf pass through SYNC_STAGES flops.
//    FSM uses the synced values only. reg_wdata is captured from BDALf_IN in the WRITE cycle.
//  - Reset: IDLE, BRPLYg=0, Outbound=0, BDALf_OE=0, BDALf_OUT=22'h3FFFFF,
//    reg_rd=reg_wr=0, reg_be=0, busy=0, timeout_err=0, timeout counter=0.
//  - FSM states and transitions:
//    IDLE  --sync SYNC--> DECODE
//    DECODE --match--> WAIT_DS; else --> IGNORE
//    WAIT_DS --DIN--> RD_REQ; --DOUT--> WRITE; --SYNC negated--> IDLE
//    RD_REQ: pulse reg_rd --> RD_SETUP
//    RD_SETUP: BDALf_OUT = {4'hF,2'b11,~reg_rdata} (upper bits released, no parity err);
//      BDALf_OE=3FFFFF, Outbound=1. After REPLY_SETUP clocks --> RD_REPLY
//    RD_REPLY: BRPLYg=1, data held. DIN negated --> RELEASE
//    WRITE: pulse reg_wr. reg_be=2'b11 if sync BWTBT negated,
//      else Qaddress[0] ? 2'b10 : 2'b01 --> WR_REPLY
//    WR_REPLY: BRPLYg=1. DOUT negated --> RELEASE
//    RELEASE: BRPLYg=0, OE=0, Outbound=0 in the same edge --> WAIT_DS if SYNC still
//      asserted (DATIO: DIN then DOUT in one SYNC), else IDLE
//    IGNORE: all outputs idle. SYNC negated --> IDLE
//  - Exactly one reg_rd per DIN and one reg_wr per DOUT. DIN and DOUT both asserted
//    in WAIT_DS: DIN wins.
//  - Timeout: counter clears on IDLE/IGNORE entry and increments in all other states.
//    At TIMEOUT_CYCLES: release all drives, set timeout_err, go to IGNORE.
//  - Sync BINIT asserted: next edge goes to IDLE with all drives released, from any state.
//    Stays in IDLE while BINIT is asserted. Registered, so no glitch on BRPLYg.
// TESTING
//  - DATI at 17772150, reg_rdata=16'o123456 -> one reg_rd, reg_addr=0.
//    BDALf_OUT[15:0]=~16'o123456 >=2 clks before BRPLYg. BRPLYg drops within 3 clks of DIN negate.
//  - DATO word at 17772152, data 16'hA5C3 -> one reg_wr, reg_addr=1, reg_be=11, reg_wdata=16'hA5C3.
//  - DATOB at 17772155 (odd) with BWTBT during DOUT -> reg_addr=2, reg_be=10.
//  - DATIO at 17772156 -> reg_rd then reg_wr in one SYNC, BRPLYg asserts twice.
//  - Address 17772160, or BBS7 negated -> IGNORE. No strobes, no BRPLYg/OE.
//  - DIN held 1100 clks -> abort at 1023, timeout_err=1, drives released.
//    BINIT mid-RD_REPLY -> IDLE next cycle, BRPLYg=0.

Source files
------------

// File: rtl/qbus_slave_seq.sv
// qbus_slave_seq
// Qbus programmed-I/O slave cycle sequencer. It sits between the Qbus pin
// drivers and a four-word register file. It decodes DATI, DATO, DATOB and
// DATIO cycles aimed at the QADDR window and turns them into single-cycle
// reg_rd/reg_wr strobes in the 'clock' domain. It drives BDAL read data with
// REPLY_SETUP clocks of setup ahead of BRPLYg, aborts cycles that hang, and
// obeys BINIT.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   BDALf_IN[21:0]    BDAL pins, inverted (low = asserted)
//   BSYNCf, BDINf, BDOUTf, BWTBTf, BBS7f, BINITf
//                     Qbus control lines, inverted, asynchronous to clock
//   BDALf_OUT[21:0]   inverted data driven onto BDAL
//   BDALf_OE[21:0]    per-pin output enables
//   Outbound          BDAL gate-driver direction enable
//   BRPLYg            BRPLY MOSFET gate (1 = assert RPLY)
//   reg_addr[1:0]     register word index (Qbus address bits [2:1])
//   reg_rd            read strobe; reg_rdata is valid the cycle after
//   reg_rdata[15:0]   read data from the register file
//   reg_wr            write strobe, with reg_be and reg_wdata valid alongside
//   reg_be[1:0]       byte enables, [1] = high byte, [0] = low byte
//   reg_wdata[15:0]   write data, true polarity
//   busy              sequencer is not idle
//   timeout_err       sticky hung-cycle flag, cleared only by reset
module qbus_slave_seq #(
  parameter logic [21:0] QADDR          = 22'o17772150,
  parameter int          SYNC_STAGES    = 2,
  parameter int          REPLY_SETUP    = 2,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [21:0] BDALf_IN,
  input  logic        BSYNCf,
  input  logic        BDINf,
  input  logic        BDOUTf,
  input  logic        BWTBTf,
  input  logic        BBS7f,
  input  logic        BINITf,
  output logic [21:0] BDALf_OUT,
  output logic [21:0] BDALf_OE,
  output logic        Outbound,
  output logic        BRPLYg,
  output logic [1:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [1:0]  reg_be,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int SW = $clog2(REPLY_SETUP + 1);

  typedef enum logic [3:0] {
    IDLE, DECODE, WAIT_DS, RD_REQ, RD_SETUP, RD_REPLY,
    WRITE, WR_REPLY, RELEASE, IGNORE
  } state_t;

  state_t      state;
  logic [9:0]  tcnt;
  logic [SW-1:0] scnt;

  // Synchronizer chains, true polarity. Bit order: {init, wtbt, dout, din, sync}.
  logic [SYNC_STAGES-1:0][4:0] sync_sh;
  logic sync_s, din_s, dout_s, wtbt_s, init_s;

  // Address phase information, latched by the BSYNC assertion edge itself.
  logic [12:0] q_addr;
  logic        q_bs7;

  // The upper BDAL bits never carry anything this slave decodes or stores.
  logic unused_bdal;
  assign unused_bdal = ^BDALf_IN[21:16];

  assign sync_s = sync_sh[SYNC_STAGES-1][0];
  assign din_s  = sync_sh[SYNC_STAGES-1][1];
  assign dout_s = sync_sh[SYNC_STAGES-1][2];
  assign wtbt_s = sync_sh[SYNC_STAGES-1][3];
  assign init_s = sync_sh[SYNC_STAGES-1][4];

  // Shift the inverted async control lines through the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_sh <= '0;
    end else begin
      sync_sh <= {sync_sh[SYNC_STAGES-2:0],
                  ~{BINITf, BWTBTf, BDOUTf, BDINf, BSYNCf}};
    end
  end

  // Capture address and BBS7 on the falling edge of BSYNCf. The FSM reads
  // these only after the synchronized SYNC, so they are long settled by then.
  always_ff @(negedge BSYNCf) begin
    q_addr <= ~BDALf_IN[12:0];
    q_bs7  <= ~BBS7f;
  end

  // Cycle sequencer with registered pin drives and register-file strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= 10'd0;
      scnt        <= '0;
      BRPLYg      <= 1'b0;
      Outbound    <= 1'b0;
      BDALf_OE    <= 22'h0;
      BDALf_OUT   <= 22'h3FFFFF;
      reg_addr    <= 2'b00;
      reg_rd      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_be      <= 2'b00;
      reg_wdata   <= 16'h0000;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      busy   <= 1'b1;
      tcnt   <= tcnt + 10'd1;
      if (init_s) begin
        // BINIT overrides everything and holds the sequencer idle.
        state     <= IDLE;
        tcnt      <= 10'd0;
        busy      <= 1'b0;
        BRPLYg    <= 1'b0;
        Outbound  <= 1'b0;
        BDALf_OE  <= 22'h0;
        BDALf_OUT <= 22'h3FFFFF;
      end else if (state != IDLE && state != IGNORE &&
                   tcnt == 10'(TIMEOUT_CYCLES)) begin
        // Hung cycle: drop every drive and sit out the rest of this SYNC.
        state       <= IGNORE;
        tcnt        <= 10'd0;
        timeout_err <= 1'b1;
        BRPLYg      <= 1'b0;
        Outbound    <= 1'b0;
        BDALf_OE    <= 22'h0;
        BDALf_OUT   <= 22'h3FFFFF;
      end else begin
        case (state)
          IDLE: begin
            tcnt <= 10'd0;
            if (sync_s) begin
              state <= DECODE;
            end else begin
              busy <= 1'b0;
            end
          end
          DECODE: begin
            reg_addr <= q_addr[2:1];
            if (q_bs7 && q_addr[12:3] == QADDR[12:3]) begin
              state <= WAIT_DS;
            end else begin
              state <= IGNORE;
              tcnt  <= 10'd0;
            end
          end
          WAIT_DS: begin
            // DIN takes priority if both data strobes show up together.
            if (din_s) begin
              state  <= RD_REQ;
              reg_rd <= 1'b1;
            end else if (dout_s) begin
              state <= WRITE;
            end else if (!sync_s) begin
              state <= IDLE;
              tcnt  <= 10'd0;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_DS;
            end
          end
          RD_REQ: begin
            // reg_rd is high during this state; data arrives next cycle.
            state <= RD_SETUP;
            scnt  <= '0;
          end
          RD_SETUP: begin
            if (scnt == '0) begin
              BDALf_OUT <= {4'hF, 2'b11, ~reg_rdata};
              BDALf_OE  <= 22'h3FFFFF;
              Outbound  <= 1'b1;
            end else begin
              BDALf_OUT <= BDALf_OUT;
            end
            // Count clocks of driven data before raising the reply.
            if (scnt == SW'(REPLY_SETUP)) begin
              BRPLYg <= 1'b1;
              state  <= RD_REPLY;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          RD_REPLY: begin
            if (!din_s) begin
              state     <= RELEASE;
              BRPLYg    <= 1'b0;
              Outbound  <= 1'b0;
              BDALf_OE  <= 22'h0;
              BDALf_OUT <= 22'h3FFFFF;
            end else begin
              state <= RD_REPLY;
            end
          end
          WRITE: begin
            reg_wr    <= 1'b1;
            reg_wdata <= ~BDALf_IN[15:0];
            // BWTBT during the data phase marks a byte write.
            if (wtbt_s) begin
              reg_be <= q_addr[0] ? 2'b10 : 2'b01;
            end else begin
              reg_be <= 2'b11;
            end
            BRPLYg <= 1'b1;
            state  <= WR_REPLY;
          end
          WR_REPLY: begin
            if (!dout_s) begin
              state  <= RELEASE;
              BRPLYg <= 1'b0;
            end else begin
              state <= WR_REPLY;
            end
          end
          RELEASE: begin
            // SYNC still asserted means a DATIO: go back for its DOUT half.
            if (sync_s) begin
              state <= WAIT_DS;
            end else begin
              state <= IDLE;
              tcnt  <= 10'd0;
              busy  <= 1'b0;
            end
          end
          IGNORE: begin
            tcnt <= 10'd0;
            if (!sync_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= IGNORE;
            end
          end
          default: begin
            state     <= IDLE;
            tcnt      <= 10'd0;
            busy      <= 1'b0;
            BRPLYg    <= 1'b0;
            Outbound  <= 1'b0;
            BDALf_OE  <= 22'h0;
            BDALf_OUT <= 22'h3FFFFF;
          end
        endcase
      end
    end
  end

endmodule
